// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter
//   Round-robin arbiter sharing the single input port of an asynchronous
//   req/ack/data stage pipeline among N_REQ local requesters. One requester
//   is granted at a time. Its word is registered and driven onto the
//   pipeline. A full four-phase return-to-zero handshake then runs on
//   pipe_req_out/pipe_ack_in, and the transaction ends with a one-cycle
//   src_done pulse.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous reset, active low
//   src_req        per-requester level request, held until its src_done pulse
//   src_data       requester i's word at [i*DATA_W +: DATA_W]
//   src_done       one-hot, one-cycle completion pulse
//   pipe_req_out   req to the pipeline
//   pipe_data_out  data to the pipeline, registered at grant
//   pipe_ack_in    ack from the pipeline, asynchronous to clk
//   busy           high in every state except IDLE
//   grant_id       index of the current or last granted requester
//   txn_count      completed transactions, wraps modulo 2^CNT_W
module pipe_rr_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 3,
  parameter  int CNT_W  = 16,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          src_req,
  input  logic [N_REQ*DATA_W-1:0]   src_data,
  output logic [N_REQ-1:0]          src_done,
  output logic                      pipe_req_out,
  output logic [DATA_W-1:0]         pipe_data_out,
  input  logic                      pipe_ack_in,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic [CNT_W-1:0]          txn_count
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              ack_sync1;
  logic              ack_s;
  logic [ID_W-1:0]   rr_ptr;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [DATA_W-1:0] words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = src_data[g*DATA_W +: DATA_W];
  end

  // Circular search starting at rr_ptr: the first active requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!win_found && src_req[ID_W'((32'(rr_ptr) + k) % NR)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((32'(rr_ptr) + k) % NR);
      end
    end
  end

  // The IDLE guard on ack_s keeps a new grant from starting while the
  // pipeline still holds ack high (e.g. after a reset mid-handshake).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (win_found && !ack_s) state_next = REQ;
      REQ:     if (ack_s)               state_next = RELEASE;
      RELEASE: if (!ack_s)              state_next = DONE;
      DONE:                             state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // All outputs are registered from the next state so that each one takes
  // its new value on the same edge as the state change it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      ack_sync1     <= 1'b0;
      ack_s         <= 1'b0;
      pipe_req_out  <= 1'b0;
      pipe_data_out <= '0;
      src_done      <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      txn_count     <= '0;
    end else begin
      ack_sync1    <= pipe_ack_in;
      ack_s        <= ack_sync1;
      state        <= state_next;
      pipe_req_out <= (state_next == REQ);
      busy         <= (state_next != IDLE);
      src_done     <= '0;
      if (state == IDLE && state_next == REQ) begin
        pipe_data_out <= words[win_id];
        grant_id      <= win_id;
      end
      if (state == RELEASE && state_next == DONE) begin
        src_done[grant_id] <= 1'b1;
        txn_count          <= txn_count + CNT_W'(1);
        rr_ptr             <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter (N_REQ=4, DATA_W=3, CNT_W=4).
// A transaction-level reference model tracks arbitration, the handshake and
// the transaction counter. A requester model and a pipeline model with
// configurable ack delays drive the DUT.
module tb_pipe_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_req;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]  src_done;
  logic          pipe_req_out;
  logic [DW-1:0] pipe_data_out;
  logic          pipe_ack_in;
  logic          busy;
  logic [1:0]    grant_id;
  logic [CW-1:0] txn_count;

  always #5 clk = ~clk;

  pipe_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data),
    .src_done(src_done), .pipe_req_out(pipe_req_out),
    .pipe_data_out(pipe_data_out), .pipe_ack_in(pipe_ack_in),
    .busy(busy), .grant_id(grant_id), .txn_count(txn_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycles   = 0;

  // reference model
  bit m_idle = 1'b1, m_done = 1'b0, m_req = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0;
  int m_ptr = 0, m_gid = 0, m_data = 0, m_cnt = 0;
  logic          obs_req_prev  = 1'b0;
  logic [DW-1:0] obs_data_prev = '0;

  // requester and pipeline environment
  int remaining [N];
  bit rand_mode = 1'b0;
  int arrivals_left = 0;
  int total_issued  = 0;
  int p_d1 = 3, p_d2 = 3, p_wait = 0;
  bit p_force = 1'b0, p_rand = 1'b0;

  // observation records
  int gseq[$], dseq[$], gcyc[$], dcyc[$], cnt_after[$];
  int done_cnt [N];
  bit cnt_pending = 1'b0;

  int exp_b  [3] = '{0, 2, 0};
  int exp_bd [3] = '{1, 3, 1};
  int exp_c  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  bit reached;
  int k_steps;
  int sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int word_of(input logic [N*DW-1:0] d, input int i);
    logic [N*DW-1:0] sh;
    sh = d >> (i * DW);
    return int'(sh[DW-1:0]);
  endfunction

  function automatic bit all_idle_reqs();
    for (int i = 0; i < N; i++) if (remaining[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_records();
    gseq.delete(); dseq.delete(); gcyc.delete(); dcyc.delete(); cnt_after.delete();
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    cnt_pending = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0]    req_e;
    logic [N*DW-1:0] data_e;
    logic            ack_e, rst_e;
    bit              idle_b, done_b, req_b, s2_b, exp_grant;
    int              win;
    logic [N-1:0]    exp_done;
    req_e = src_req; data_e = src_data; ack_e = pipe_ack_in; rst_e = rst;
    idle_b = m_idle; done_b = m_done; req_b = m_req; s2_b = m_s2;
    @(posedge clk);
    #1;
    cycles++;
    exp_grant = 1'b0; win = 0; exp_done = '0;

    // reference model for the edge just taken
    if (!rst_e) begin
      m_idle = 1'b1; m_done = 1'b0; m_req = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      m_ptr = 0; m_gid = 0; m_data = 0; m_cnt = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = ack_e;
      if (done_b) begin
        m_idle = 1'b1;
        m_done = 1'b0;
      end else if (idle_b) begin
        if (req_e != '0 && !s2_b) begin
          for (int k = 0; k < N; k++)
            if (!exp_grant && req_e[(m_ptr + k) % N]) begin
              exp_grant = 1'b1;
              win = (m_ptr + k) % N;
            end
          m_idle = 1'b0; m_req = 1'b1; m_gid = win; m_data = word_of(data_e, win);
        end
      end else if (req_b) begin
        if (s2_b) m_req = 1'b0;
      end else if (!s2_b) begin
        m_done = 1'b1;
        exp_done[m_gid] = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_ptr = (m_gid + 1) % N;
      end
    end

    chk("pipe_req_out", pipe_req_out, m_req);
    chk("busy", busy, !m_idle);
    chk("src_done", src_done, exp_done);
    chk("pipe_data_out", pipe_data_out, m_data);
    chk("grant_id", grant_id, m_gid);
    if (m_idle) chk("txn_count", txn_count, m_cnt);

    // handshake ordering relative to the synchronized ack
    if (rst_e && obs_req_prev === 1'b1 && pipe_req_out === 1'b0) chk("req_fall_needs_ack_s_high", s2_b, 1);
    if (rst_e && obs_req_prev === 1'b0 && pipe_req_out === 1'b1) chk("req_rise_needs_ack_s_low", s2_b, 0);
    if (rst_e && (obs_req_prev === 1'b1 || s2_b)) chk("data_stable_in_handshake", pipe_data_out, obs_data_prev);

    if (rst_e && obs_req_prev === 1'b0 && pipe_req_out === 1'b1) begin
      gseq.push_back(int'(grant_id));
      dseq.push_back(int'(pipe_data_out));
      gcyc.push_back(cycles);
    end
    obs_req_prev  = pipe_req_out;
    obs_data_prev = pipe_data_out;

    if (m_idle && cnt_pending) begin
      cnt_after.push_back(int'(txn_count));
      cnt_pending = 1'b0;
    end
    if (src_done != '0) begin
      cnt_pending = 1'b1;
      dcyc.push_back(cycles);
    end

    // requesters: drop on completion, optionally re-arm with new words
    for (int i = 0; i < N; i++) begin
      if (src_done[i] === 1'b1) begin
        done_cnt[i]++;
        if (remaining[i] > 0) begin
          remaining[i]--;
          if (rand_mode) src_data[i*DW +: DW] = DW'($urandom_range(0, 7));
        end
      end
    end
    if (rand_mode)
      for (int i = 0; i < N; i++)
        if (remaining[i] == 0 && arrivals_left > 0 && $urandom_range(0, 3) == 0) begin
          remaining[i] = 1 + $urandom_range(0, 1);
          total_issued += remaining[i];
          src_data[i*DW +: DW] = DW'($urandom_range(0, 7));
          arrivals_left--;
        end
    for (int i = 0; i < N; i++) src_req[i] = (remaining[i] > 0);

    // pipeline: follow req with a configurable delay
    if (p_force) pipe_ack_in = 1'b1;
    else if (pipe_req_out !== pipe_ack_in) begin
      if (p_wait >= (pipe_req_out ? p_d1 : p_d2)) begin
        pipe_ack_in = pipe_req_out;
        p_wait = 0;
        if (p_rand) begin
          p_d1 = $urandom_range(0, 4);
          p_d2 = $urandom_range(0, 4);
        end
      end else p_wait++;
    end else p_wait = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; p_force = 1'b0; pipe_ack_in = 1'b0; p_wait = 0;
    arrivals_left = 0; rand_mode = 1'b0; p_rand = 1'b0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    src_req = '0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      step();
      fin = all_idle_reqs() && arrivals_left == 0 && m_idle && !m_done;
    end
    chk("drain_complete", fin, 1);
  endtask

  initial begin
    rst = 1'b0; src_req = '0; src_data = '0; pipe_ack_in = 1'b0;
    for (int i = 0; i < N; i++) begin remaining[i] = 0; done_cnt[i] = 0; end

    // reset values
    do_reset(3);
    chk("reset_pipe_req_out", pipe_req_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_txn_count", txn_count, 0);
    chk("reset_grant_id", grant_id, 0);

    // single request, word 5, pipeline answering after 3 cycles
    clear_records();
    p_d1 = 3; p_d2 = 3;
    src_data = 12'h005; remaining[0] = 1; src_req = 4'b0001;
    drain(200);
    chk("single_grants", gseq.size(), 1);
    if (dseq.size() > 0) chk("single_data", dseq[0], 5);
    chk("single_done0", done_cnt[0], 1);
    chk("single_done_others", done_cnt[1] + done_cnt[2] + done_cnt[3], 0);
    chk("single_txn_count", txn_count, 1);
    chk("single_req_low", pipe_req_out, 0);

    // two simultaneous requesters 0 and 2
    do_reset(2);
    clear_records();
    src_data = {3'd0, 3'd3, 3'd0, 3'd1};
    remaining[0] = 2; remaining[2] = 1; src_req = 4'b0101;
    drain(300);
    chk("simul_grants", gseq.size(), 3);
    for (int i = 0; i < 3; i++)
      if (gseq.size() > i) begin
        chk("simul_grant_id", gseq[i], exp_b[i]);
        chk("simul_data", dseq[i], exp_bd[i]);
      end
    chk("simul_done0", done_cnt[0], 2);
    chk("simul_done2", done_cnt[2], 1);

    // fairness with all four active and an instantly answering pipeline
    do_reset(2);
    clear_records();
    p_d1 = 0; p_d2 = 0;
    src_data = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < N; i++) remaining[i] = 2;
    src_req = 4'b1111;
    drain(400);
    chk("fair_grants", gseq.size(), 8);
    for (int i = 0; i < 8; i++)
      if (gseq.size() > i) begin
        chk("fair_grant_id", gseq[i], exp_c[i]);
        chk("fair_data", dseq[i], exp_c[i] + 1);
      end
    for (int i = 0; i < N; i++) chk("fair_done_per_bit", done_cnt[i], 2);
    if (gcyc.size() > 1 && dcyc.size() > 0) begin
      chk("fair_grant_to_done", dcyc[0] - gcyc[0], 6);
      chk("fair_done_to_next_grant", gcyc[1] - dcyc[0], 2);
    end

    // reset in REQ with ack high
    clear_records();
    p_d1 = 3; p_d2 = 3;
    src_data = {3'd0, 3'd0, 3'd6, 3'd0};
    remaining[1] = 1; src_req = 4'b0010;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step();
      if (pipe_req_out === 1'b1 && pipe_ack_in === 1'b1) reached = 1'b1;
    end
    chk("abort_reach_req_ack", reached, 1);
    p_force = 1'b1; rst = 1'b0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    src_req = '0;
    step();
    chk("abort_req_low", pipe_req_out, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_no_done", src_done, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin remaining[1] = 1; src_req = 4'b0010; end
      step();
      chk("abort_no_grant_ack_high", pipe_req_out, 0);
      chk("abort_idle_ack_high", busy, 0);
    end
    p_force = 1'b0; pipe_ack_in = 1'b0; p_wait = 0;
    reached = 1'b0; k_steps = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      step();
      k_steps++;
      if (pipe_req_out === 1'b1) reached = 1'b1;
    end
    chk("abort_regrant", reached, 1);
    chk("abort_regrant_latency", k_steps, 3);
    drain(200);
    chk("abort_done1", done_cnt[1], 1);
    chk("abort_done_others", done_cnt[0] + done_cnt[2] + done_cnt[3], 0);
    chk("abort_grants", dseq.size(), 2);

    // randomized traffic and pipeline delays
    clear_records();
    rand_mode = 1'b1; p_rand = 1'b1; arrivals_left = 40; total_issued = 0;
    drain(4000);
    sum = 0;
    for (int i = 0; i < N; i++) sum += done_cnt[i];
    chk("random_all_completed", sum, total_issued);
    rand_mode = 1'b0; p_rand = 1'b0;

    // counter wrap over 17 transactions
    do_reset(2);
    clear_records();
    p_d1 = 0; p_d2 = 0;
    src_data = {3'd7, 3'd0, 3'd0, 3'd0};
    remaining[3] = 17; src_req = 4'b1000;
    drain(1000);
    chk("wrap_txn_records", cnt_after.size(), 17);
    if (cnt_after.size() >= 17) begin
      chk("wrap_after_15", cnt_after[14], 15);
      chk("wrap_after_16", cnt_after[15], 0);
      chk("wrap_after_17", cnt_after[16], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
